// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a byte FIFO feeding an 8N1 serialiser on TXD.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA,
    input  logic       DATA_READY,
    output logic       FULL,
    output logic       IDLE,
    output logic       OVERRUN,
    output logic       TXD
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    logic [7:0]            mem_reg [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic                  full_reg;
    logic                  overrun_reg;
    logic                  idle_reg;
    logic                  txd_reg;
    state_t                state_reg;
    logic [BW-1:0]         baud_reg;
    logic [2:0]            bit_idx_reg;
    logic [7:0]            shift_reg;
    logic                  wr_en;
    logic                  pop;
    logic                  baud_last;
`ifdef UART_TX_PARITY_EN
    logic                  parity_reg;
`endif

    // Acceptance looks only at the registered FULL; a same-cycle pop frees nothing.
    assign wr_en     = DATA_READY && !full_reg;
    assign baud_last = (baud_reg == BAUD_LAST);
    assign pop       = (count_reg != '0) &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_last));

    always_comb begin
        count_next = count_reg;
        if (wr_en && !pop)
            count_next = count_reg + 1'b1;
        else if (!wr_en && pop)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem_reg[wr_ptr_reg] <= DATA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            full_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            idle_reg    <= 1'b1;
            txd_reg     <= 1'b1;
            state_reg   <= ST_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == COUNT_FULL);
            if (DATA_READY && full_reg)
                overrun_reg <= 1'b1;

            // Line and idle outputs are registered from the current state, one cycle behind it.
            idle_reg <= (state_reg == ST_IDLE) && (count_reg == '0);
            case (state_reg)
                ST_START:  txd_reg <= 1'b0;
                ST_DATA:   txd_reg <= shift_reg[0];
`ifdef UART_TX_PARITY_EN
                ST_PARITY: txd_reg <= parity_reg;
`endif
                default:   txd_reg <= 1'b1;
            endcase

            baud_reg <= ((state_reg == ST_IDLE) || baud_last) ? '0 : baud_reg + 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        shift_reg <= mem_reg[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
                        parity_reg <= ^mem_reg[rd_ptr_reg];
`endif
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        bit_idx_reg <= '0;
                        state_reg   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_reg <= ST_PARITY;
`else
                            state_reg <= ST_STOP;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_last)
                        state_reg <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    if (baud_last) begin
                        if (pop) begin
                            shift_reg <= mem_reg[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
                            parity_reg <= ^mem_reg[rd_ptr_reg];
`endif
                            state_reg <= ST_START;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign FULL    = full_reg;
    assign IDLE    = idle_reg;
    assign OVERRUN = overrun_reg;
    assign TXD     = txd_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo: a schedule model predicts acceptance, pop
// times and frame start cycles; a line monitor decodes TXD and compares.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] DATA = 8'h00;
    logic       DATA_READY = 1'b0;
    logic       FULL;
    logic       IDLE;
    logic       OVERRUN;
    logic       TXD;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
        .CLK(CLK),
        .RST(RST),
        .DATA(DATA),
        .DATA_READY(DATA_READY),
        .FULL(FULL),
        .IDLE(IDLE),
        .OVERRUN(OVERRUN),
        .TXD(TXD)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int rst_count = 0;
    always @(negedge RST) rst_count++;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: every accepted byte is popped at max(write edge + 1, previous pop + FRAME);
    // its start bit appears on the line one cycle after the pop.
    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;
    exp_t exp_q[$];
    int   acc_q[$];
    int   pop_q[$];
    int   ovr_edge = -1;
    bit   chk_en = 1'b0;

    function automatic int occ(input int t);
        int n = 0;
        foreach (acc_q[i]) if (acc_q[i] <= t) n++;
        foreach (pop_q[i]) if (pop_q[i] <= t) n--;
        return n;
    endfunction

    function automatic bit busy(input int t);
        foreach (pop_q[i]) if (pop_q[i] <= t && t <= pop_q[i] + FRAME - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wr(input logic [7:0] b, output bit accepted, output int e);
        int   p;
        exp_t x;
        DATA = b;
        DATA_READY = 1'b1;
        @(posedge CLK);
        #1;
        DATA_READY = 1'b0;
        e = cyc;
        accepted = (occ(e - 1) < DEPTH);
        if (accepted) begin
            p = e + 1;
            if (pop_q.size() > 0 && pop_q[$] + FRAME > p) p = pop_q[$] + FRAME;
            acc_q.push_back(e);
            pop_q.push_back(p);
            x.b = b;
            x.start = p + 1;
            exp_q.push_back(x);
        end else if (ovr_edge < 0) begin
            ovr_edge = e;
        end
        $display("write 0x%02h at cycle %0d %s", b, e, accepted ? "accepted" : "dropped");
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || IDLE !== 1'b1) && n < 20 * FRAME) begin
            @(negedge CLK);
            n++;
        end
        chk(name, int'(n < 20 * FRAME), 1);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("full", int'(FULL), int'(occ(cyc) == DEPTH));
            chk("idle", int'(IDLE), int'(occ(cyc - 1) == 0 && !busy(cyc - 1)));
            chk("overrun", int'(OVERRUN), int'(ovr_edge >= 0 && ovr_edge <= cyc));
        end
    end

    initial begin : monitor
        logic       prev;
        logic [7:0] bits;
        logic       st;
        logic       sp;
        int         t0;
        int         r0;
        exp_t       x;
`ifdef UART_TX_PARITY_EN
        logic       par;
`endif
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (RST && prev && !TXD) begin
                t0 = cyc;
                r0 = rst_count;
                repeat (CPB / 2) @(negedge CLK);
                st = TXD;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    bits[i] = TXD;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge CLK);
                par = TXD;
`endif
                repeat (CPB) @(negedge CLK);
                sp = TXD;
                repeat (CPB - CPB / 2 - 1) @(negedge CLK);
                if (rst_count == r0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got 0x%02h at cycle %0d expected none", bits, t0);
                    end else begin
                        x = exp_q.pop_front();
                        chk("frame_byte", int'(bits), int'(x.b));
                        chk("frame_start", t0, x.start);
                        chk("start_bit", int'(st), 0);
                        chk("stop_bit", int'(sp), 1);
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", int'(par), int'(^x.b));
`endif
                        $display("frame 0x%02h start cycle %0d", bits, t0);
                    end
                end
            end
            prev = TXD;
        end
    end

    initial begin : stim
        bit a;
        int e0;
        int n;
        int guard;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_txd", int'(TXD), 1);
        chk("reset_idle", int'(IDLE), 1);
        chk("reset_full", int'(FULL), 0);
        chk("reset_overrun", int'(OVERRUN), 0);
        RST = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Single byte: start bit latency and IDLE return time
        wr(8'h55, a, e0);
        @(negedge CLK);
        @(negedge CLK);
        chk("t1_txd_e1", int'(TXD), 1);
        @(negedge CLK);
        chk("t1_txd_e2", int'(TXD), 0);
        n = 0;
        while (IDLE !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("t1_idle_rise", cyc - e0, FRAME + 2);
        wait_idle("t1_done");

        // Back-to-back burst: contiguous frames in write order
        wr(8'hA3, a, e0);
        wr(8'h0F, a, e0);
        wr(8'hFF, a, e0);
        wait_idle("t2_done");

        // Overflow: six consecutive writes into a depth-4 FIFO
        n = 0;
        for (int v = 1; v <= 6; v++) begin
            wr(8'(v), a, e0);
            if (a) n++;
        end
        chk("t3_accepted", n, 5);
        chk("t3_full", int'(FULL), 1);
        chk("t3_overrun", int'(OVERRUN), 1);
        wait_idle("t3_done");

        // Reset during data bit 3 of 0x81, then a clean 0x7E
        wr(8'h81, a, e0);
        while (cyc < e0 + 19) @(negedge CLK);
        chk("t5_bit3_before", int'(TXD), 0);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        chk_en = 1'b0;
        #1;
        chk("t5_txd_async", int'(TXD), 1);
        chk("t5_idle_async", int'(IDLE), 1);
        chk("t5_full_async", int'(FULL), 0);
        acc_q.delete();
        pop_q.delete();
        exp_q.delete();
        ovr_edge = -1;
        repeat (3) @(posedge CLK);
        #3;
        RST = 1'b1;
        chk_en = 1'b1;
        repeat (60) @(posedge CLK);
        #1;
        wr(8'h7E, a, e0);
        wait_idle("t5_done");

        // 20 random bytes, writing only when the FIFO has room
        n = 0;
        guard = 0;
        while (n < 20 && guard < 5000) begin
            if (occ(cyc) < DEPTH && $urandom_range(0, 3) != 0) begin
                wr(8'($urandom_range(0, 255)), a, e0);
                if (a) n++;
            end else begin
                @(posedge CLK);
                #1;
            end
            guard++;
        end
        chk("t4_count", n, 20);
        wait_idle("t4_done");

        // Parity-sensitive bytes (odd and even weight)
        wr(8'h07, a, e0);
        wr(8'h03, a, e0);
        wait_idle("t6_done");

        chk("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
